// File: rtl/adder_tree_pipelined.sv
// Pipelined population-count adder tree with a valid/ready handshake.
// Each tree level sums adjacent partial sums from the previous level into
// a register stage. The whole pipeline freezes when the final result is
// valid but not consumed.
module adder_tree_pipelined #(
    parameter  int NUM_INPUTS = 8,
    localparam int SUM_W      = $clog2(NUM_INPUTS + 1),
    localparam int LEVELS     = $clog2(NUM_INPUTS)
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [NUM_INPUTS-1:0] inputs,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [SUM_W-1:0]      sum,
    output logic                  out_valid,
    input  logic                  out_ready
);

    // Number of partial sums held at level k (level 0 is the raw input bits).
    function automatic int cnt_at(input int k);
        int n;
        n = NUM_INPUTS;
        for (int i = 0; i < k; i++) begin
            n = (n + 1) / 2;
        end
        return n;
    endfunction

    // Width of each partial sum at level k: k+1 bits, capped at the output width.
    function automatic int wid_at(input int k);
        return ((k + 1) < SUM_W) ? (k + 1) : SUM_W;
    endfunction

    // Bit offset of level k inside the flattened tree bus.
    function automatic int off_at(input int k);
        int o;
        o = 0;
        for (int i = 0; i < k; i++) begin
            o = o + cnt_at(i) * wid_at(i);
        end
        return o;
    endfunction

    localparam int TOT_W    = off_at(LEVELS + 1);
    localparam int LAST_OFF = off_at(LEVELS);

    // All levels of partial sums, level 0 at the LSB end.
    logic [TOT_W-1:0]  tree_s;
    // Valid bits of the register stages; vld_s[LEVELS] is the output stage.
    logic [LEVELS:1]   vld_s;
    logic              stall_s;
    logic              acc_s;

    assign stall_s  = vld_s[LEVELS] && !out_ready;
    assign in_ready = !stall_s;
    assign acc_s    = in_valid && !stall_s;

    assign tree_s[NUM_INPUTS-1:0] = inputs;

    genvar k;
    for (k = 1; k <= LEVELS; k++) begin : g_stage
        localparam int CNT  = cnt_at(k);
        localparam int W    = wid_at(k);
        localparam int OFF  = off_at(k);
        localparam int PCNT = cnt_at(k - 1);
        localparam int PW   = wid_at(k - 1);
        localparam int POFF = off_at(k - 1);

        logic [CNT*W-1:0] data_d;
        logic [CNT*W-1:0] data_q;
        logic             vld_d;
        logic             vld_q;
        logic             prev_vld_s;

        if (k == 1) begin : g_first
            assign prev_vld_s = acc_s;
        end else begin : g_inner
            assign prev_vld_s = vld_s[k-1];
        end

        // Pair adjacent partial sums (odd leftover zero-extended); hold on stall.
        always_comb begin
            data_d = data_q;
            vld_d  = vld_q;
            if (!stall_s) begin
                vld_d = prev_vld_s;
                for (int j = 0; j < CNT; j++) begin
                    if ((2 * j + 1) < PCNT) begin
                        data_d[j*W +: W] = W'(tree_s[POFF + 2*j*PW +: PW])
                                         + W'(tree_s[POFF + (2*j+1)*PW +: PW]);
                    end else begin
                        data_d[j*W +: W] = W'(tree_s[POFF + 2*j*PW +: PW]);
                    end
                end
            end else begin
                data_d = data_q;
                vld_d  = vld_q;
            end
        end

        // Stage register with synchronous clear of data and valid.
        always_ff @(posedge CLK) begin
            if (!nRST) begin
                data_q <= '0;
                vld_q  <= 1'b0;
            end else begin
                data_q <= data_d;
                vld_q  <= vld_d;
            end
        end

        assign tree_s[OFF +: CNT*W] = data_q;
        assign vld_s[k]             = vld_q;
    end

    assign sum       = tree_s[LAST_OFF +: SUM_W];
    assign out_valid = vld_s[LEVELS];

endmodule

// File: tb/tb_adder_tree_pipelined.sv
// Bench for adder_tree_pipelined: five instances (N = 8, 5, 2, 64, 3),
// directed latency/bubble/stall/reset sequences plus a randomized handshake
// run scored against a popcount queue model.
module tb_adder_tree_pipelined;

    localparam int NI = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nrst;
    logic [63:0] vec  [NI];
    logic        iv   [NI];
    logic        ordy [NI];
    logic        ir   [NI];
    logic        ov   [NI];
    logic [6:0]  sm   [NI];

    int nin [NI] = '{8, 5, 2, 64, 3};
    int lev [NI] = '{3, 3, 1, 6, 2};

    logic [3:0] s0;
    logic [2:0] s1;
    logic [1:0] s2;
    logic [6:0] s3;
    logic [1:0] s4;

    assign sm[0] = 7'(s0);
    assign sm[1] = 7'(s1);
    assign sm[2] = 7'(s2);
    assign sm[3] = s3;
    assign sm[4] = 7'(s4);

    adder_tree_pipelined #(.NUM_INPUTS(8)) u_n8 (
        .CLK(clk), .nRST(nrst), .inputs(vec[0][7:0]), .in_valid(iv[0]),
        .in_ready(ir[0]), .sum(s0), .out_valid(ov[0]), .out_ready(ordy[0]));
    adder_tree_pipelined #(.NUM_INPUTS(5)) u_n5 (
        .CLK(clk), .nRST(nrst), .inputs(vec[1][4:0]), .in_valid(iv[1]),
        .in_ready(ir[1]), .sum(s1), .out_valid(ov[1]), .out_ready(ordy[1]));
    adder_tree_pipelined #(.NUM_INPUTS(2)) u_n2 (
        .CLK(clk), .nRST(nrst), .inputs(vec[2][1:0]), .in_valid(iv[2]),
        .in_ready(ir[2]), .sum(s2), .out_valid(ov[2]), .out_ready(ordy[2]));
    adder_tree_pipelined #(.NUM_INPUTS(64)) u_n64 (
        .CLK(clk), .nRST(nrst), .inputs(vec[3]), .in_valid(iv[3]),
        .in_ready(ir[3]), .sum(s3), .out_valid(ov[3]), .out_ready(ordy[3]));
    adder_tree_pipelined #(.NUM_INPUTS(3)) u_n3 (
        .CLK(clk), .nRST(nrst), .inputs(vec[4][2:0]), .in_valid(iv[4]),
        .in_ready(ir[4]), .sum(s4), .out_valid(ov[4]), .out_ready(ordy[4]));

    int n_vec = 0;
    int n_err = 0;

    int unsigned exp_q [NI][$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: number of ones among the low n bits.
    function automatic int pc(input logic [63:0] v, input int n);
        logic [63:0] m;
        m = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
        return $countones(v & m);
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_all();
        for (int i = 0; i < NI; i++) begin
            iv[i]   = 1'b0;
            ordy[i] = 1'b1;
            vec[i]  = 64'd0;
        end
    endtask

    // Directed sequence on one instance, out_ready held high.
    task automatic run_dir(input int i, input string tag,
                           input logic [63:0] v [8], input bit vf [8]);
        int L;
        int idx;
        bit ev;
        L = lev[i];
        for (int t = 0; t < 8 + L; t++) begin
            if (t < 8) begin
                iv[i]  = vf[t];
                vec[i] = v[t];
            end else begin
                iv[i]  = 1'b0;
                vec[i] = 64'd0;
            end
            step();
            idx = t - L + 1;
            ev  = 1'b0;
            if (idx >= 0 && idx < 8) ev = vf[idx];
            check_eq($sformatf("%s valid t%0d", tag, t), ov[i], ev);
            if (ev) check_eq($sformatf("%s sum t%0d", tag, t), sm[i], pc(v[idx], nin[i]));
        end
    endtask

    // Handshake stream with scoreboard; rnd=0 is the scheduled stall on N=8.
    task automatic run_stream(input int ncyc, input bit rnd);
        logic [6:0] hold_sum [NI];
        bit was_stall [NI];
        bit acc_last [NI];
        int acc [NI];
        bit active;
        bit feeding;
        bit drain;
        for (int i = 0; i < NI; i++) begin
            was_stall[i] = 1'b0;
            acc_last[i]  = 1'b1;
            acc[i]       = 0;
            hold_sum[i]  = 7'd0;
            exp_q[i].delete();
        end
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            drain = (cyc >= ncyc - 12);
            for (int i = 0; i < NI; i++) begin
                active = rnd || (i == 0);
                if (drain || !active) ordy[i] = 1'b1;
                else if (rnd) ordy[i] = ($urandom_range(0, 9) < 6);
                else ordy[i] = !(cyc >= 4 && cyc < 8);
                feeding = active && !drain && (rnd || acc[i] < 6);
                if (acc_last[i] || !iv[i]) begin
                    iv[i]  = feeding && (rnd ? ($urandom_range(0, 9) < 7) : 1'b1);
                    vec[i] = {$urandom, $urandom};
                end
            end
            #1;
            for (int i = 0; i < NI; i++) begin
                check_eq($sformatf("s%0d in_ready c%0d", i, cyc), ir[i], !(ov[i] && !ordy[i]));
                if (was_stall[i]) begin
                    check_eq($sformatf("s%0d held valid c%0d", i, cyc), ov[i], 1'b1);
                    check_eq($sformatf("s%0d held sum c%0d", i, cyc), sm[i], hold_sum[i]);
                end
                if (ov[i] && ordy[i]) begin
                    check_eq($sformatf("s%0d result expected c%0d", i, cyc), exp_q[i].size() != 0, 1'b1);
                    if (exp_q[i].size() != 0)
                        check_eq($sformatf("s%0d sum c%0d", i, cyc), sm[i], exp_q[i].pop_front());
                end
                was_stall[i] = ov[i] && !ordy[i];
                hold_sum[i]  = sm[i];
                acc_last[i]  = iv[i] && ir[i];
                if (acc_last[i]) begin
                    exp_q[i].push_back(pc(vec[i], nin[i]));
                    acc[i]++;
                end
            end
            step();
        end
        for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("s%0d undelivered", i), exp_q[i].size(), 0);
            if (ov[i]) check_eq($sformatf("s%0d stray valid", i), ov[i], 1'b0);
        end
        if (!rnd) check_eq("stall accepted count", acc[0], 6);
        idle_all();
    endtask

    logic [63:0] dv [8];
    bit          df [8];

    initial begin
        nrst = 1'b0;
        idle_all();
        step();
        step();
        for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("rst valid %0d", i), ov[i], 1'b0);
            check_eq($sformatf("rst sum %0d", i), sm[i], 7'd0);
            check_eq($sformatf("rst in_ready %0d", i), ir[i], 1'b1);
        end
        nrst = 1'b1;
        step();

        // Back-to-back FF, 00, A5 on N=8.
        dv = '{64'hFF, 64'h00, 64'hA5, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
        df = '{1, 1, 1, 0, 0, 0, 0, 0};
        run_dir(0, "n8 burst", dv, df);

        // Odd operand padding on N=5.
        dv = '{64'h1F, 64'h10, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
        df = '{1, 1, 0, 0, 0, 0, 0, 0};
        run_dir(1, "n5 odd", dv, df);

        // All patterns on N=2.
        dv = '{64'h0, 64'h1, 64'h2, 64'h3, 64'h0, 64'h0, 64'h0, 64'h0};
        df = '{1, 1, 1, 1, 0, 0, 0, 0};
        run_dir(2, "n2 all", dv, df);

        // Alternating valid/bubble on N=8.
        for (int t = 0; t < 8; t++) begin
            dv[t] = {$urandom, $urandom};
            df[t] = ((t % 2) == 0);
        end
        run_dir(0, "n8 alt", dv, df);

        // Scheduled four-cycle stall in a six-vector stream.
        run_stream(30, 1'b0);

        // Reset with three vectors in flight and out_ready low.
        ordy[0] = 1'b0;
        for (int t = 0; t < 3; t++) begin
            iv[0]  = 1'b1;
            vec[0] = 64'hFF;
            step();
        end
        check_eq("rst2 pre valid", ov[0], 1'b1);
        nrst   = 1'b0;
        iv[0]  = 1'b1;
        vec[0] = 64'hFF;
        step();
        nrst  = 1'b1;
        iv[0] = 1'b0;
        #1;
        check_eq("rst2 valid", ov[0], 1'b0);
        check_eq("rst2 sum", sm[0], 7'd0);
        check_eq("rst2 in_ready", ir[0], 1'b1);
        ordy[0] = 1'b1;
        for (int t = 0; t < 6; t++) begin
            step();
            check_eq($sformatf("rst2 no stale t%0d", t), ov[0], 1'b0);
        end

        // Randomized handshake on all sizes.
        run_stream(600, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
